// File: rtl/stopwatch_button_ctrl.sv
// Stopwatch button front end: 2-flop sync, debounce and press-edge detect for three
// buttons, plus the run/pause/lap/clear FSM. Define LONG_PRESS_CLEAR_EN for hold-to-clear.
module stopwatch_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 200000000,
  parameter int CNT_W           = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       start,
  output logic       clear_pulse,
  output logic       lap_freeze,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (CNT_W < $clog2(DEBOUNCE_CYCLES + 1) || CNT_W < $clog2(HOLD_CYCLES + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow for DEBOUNCE_CYCLES/HOLD_CYCLES");
  end

  // Bit 0 = start/stop, bit 1 = clear, bit 2 = lap.
  logic [2:0]            btn_raw;
  logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]            deb_q, deb_d, deb_prev_q, deb_prev_d, evt_q, evt_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic                  clear_pulse_q, clear_pulse_d;
  logic                  long_fire;

  assign btn_raw = {btn_lap, btn_clear, btn_start_stop};

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    deb_prev_d = deb_q;
    evt_d      = deb_q & ~deb_prev_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef LONG_PRESS_CLEAR_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] hold_q, hold_d;

  // Counter parks at HOLD_MAX so a single hold fires exactly once.
  always_comb begin
    hold_d    = hold_q;
    long_fire = 1'b0;
    if (!deb_q[0]) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + CNT_W'(1);
      if (hold_q == HOLD_LAST) long_fire = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_q <= '0;
    else      hold_q <= hold_d;
  end
`else
  assign long_fire = 1'b0;
`endif

  // Priority clear > start_stop > lap; events invalid in the current state fall through.
  always_comb begin
    state_d       = state_q;
    clear_pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (evt_q[1])      clear_pulse_d = 1'b1;
        else if (evt_q[0]) state_d = S_RUN;
      end
      S_RUN: begin
        if (evt_q[0])      state_d = S_PAUSE;
        else if (evt_q[2]) state_d = S_LAP;
      end
      S_LAP: begin
        if (evt_q[0])      state_d = S_PAUSE;
        else if (evt_q[2]) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (evt_q[1]) begin
          clear_pulse_d = 1'b1;
          state_d       = S_IDLE;
        end else if (evt_q[0]) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (long_fire) begin
      clear_pulse_d = 1'b1;
      state_d       = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      deb_q         <= '0;
      deb_prev_q    <= '0;
      evt_q         <= '0;
      cnt_q         <= '0;
      state_q       <= S_IDLE;
      clear_pulse_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      deb_prev_q    <= deb_prev_d;
      evt_q         <= evt_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      clear_pulse_q <= clear_pulse_d;
    end
  end

  assign state       = state_q;
  assign start       = (state_q == S_RUN) || (state_q == S_LAP);
  assign lap_freeze  = (state_q == S_LAP);
  assign clear_pulse = clear_pulse_q;

endmodule
